// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path and a debug/loader port.
// Optional build macro DMEM_ARB_RR_EN selects round-robin conflict resolution instead of CPU priority.
module dmem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  output logic                  cpu_stall,
  output logic [WIDTH-1:0]      cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0]      dbg_wdata,
  output logic                  dbg_gnt,
  output logic [WIDTH-1:0]      dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  logic   cpu_grant;
  logic   dbg_grant;
  logic   rd_valid_q;
  owner_e rd_owner_q;

`ifdef DMEM_ARB_RR_EN
  owner_e last_gnt_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!rst) begin
      if (cpu_req && dbg_req) begin
        dbg_grant = (last_gnt_q == OWN_CPU);
        cpu_grant = (last_gnt_q == OWN_DBG);
      end else begin
        cpu_grant = cpu_req;
        dbg_grant = dbg_req;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= OWN_CPU;
    end else if (dbg_grant) begin
      last_gnt_q <= OWN_DBG;
    end else if (cpu_grant) begin
      last_gnt_q <= OWN_CPU;
    end
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q;
  logic          starved;

  assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!rst) begin
      dbg_grant = dbg_req && (!cpu_req || starved);
      cpu_grant = cpu_req && !dbg_grant;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !dbg_req || dbg_grant) begin
      starve_cnt_q <= '0;
    end else if (!starved) begin
      starve_cnt_q <= starve_cnt_q + CW'(1);
    end
  end
`endif

  // Memory port follows whichever requester won; idle cycles drive all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read tag: which requester owns the data the memory returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CPU;
    end else begin
      rd_valid_q <= mem_en && !mem_we;
      rd_owner_q <= dbg_grant ? OWN_DBG : OWN_CPU;
    end
  end

  // Outputs are forced low while reset is held, even with a read still tagged.
  assign cpu_stall  = cpu_req && !cpu_grant && !rst;
  assign dbg_gnt    = dbg_req && dbg_grant;
  assign cpu_rvalid = rd_valid_q && (rd_owner_q == OWN_CPU) && !rst;
  assign dbg_rvalid = rd_valid_q && (rd_owner_q == OWN_DBG) && !rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule
